// File: rtl/disparity_pkg.sv
// disparity_pkg: shared types and helpers for the disparity tracker.
//   state_t  - window FSM states (ACCUM collects samples, REPORT holds a report)
//   DISP_W   - width of a per-sample signed disparity (-8..+8 fits in 5 bits)
//   disp_of  - maps a ones-count of an 8-bit word to its disparity 2*count-8;
//              an illegal count (>8) contributes 0.
package disparity_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  localparam int DISP_W = 5;

  function automatic logic signed [DISP_W-1:0] disp_of(input logic [3:0] count);
    logic signed [DISP_W:0] t;
    if (count > 4'd8) return '0;
    t = $signed({1'b0, count, 1'b0}) - 6'sd8;
    return t[DISP_W-1:0];
  endfunction

endpackage

// File: rtl/sat_acc.sv
// sat_acc: signed saturating accumulator.
//   clk, reset - clock and asynchronous active-high reset (acc -> 0)
//   clr        - synchronous clear to 0, wins over en
//   en         - add d into acc this cycle
//   d          - signed per-sample disparity (DISP_W bits)
//   acc        - signed ACC_W-bit sum, clamped to the representable range
module sat_acc
  import disparity_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DISP_W-1:0] d,
  output logic signed [ACC_W-1:0]  acc
);

  // One extra bit of headroom: if the two top bits of the wide sum differ,
  // the true result lies outside ACC_W and is pinned to the nearest limit.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0]  a,
    input logic signed [DISP_W-1:0] b
  );
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W+1-DISP_W){b[DISP_W-1]}}, b};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sat_add(acc, d);
  end

endmodule

// File: rtl/disparity_tracker.sv
// disparity_tracker: accumulates per-word running disparity from ones-counts
// and emits one report per window of WINDOW accepted samples (or earlier on
// flush).
//   clk, reset               - clock, asynchronous active-high reset
//   in_valid/in_ready, count - sample stream (count = ones in an 8-bit word)
//   flush                    - close a non-empty window early
//   out_valid/out_ready      - report handshake
//   out_sum                  - signed saturated window disparity
//   out_imbalance            - |out_sum| > THRESH
//   out_partial              - report closed by flush before WINDOW samples
//   running_disp             - saturated disparity since reset, never cleared
//   err                      - sticky: a count > 8 was accepted
module disparity_tracker
  import disparity_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int THRESH = 12,
  parameter int ACC_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              count,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_imbalance,
  output logic                    out_partial,
  output logic signed [ACC_W-1:0] running_disp,
  output logic                    err
);

  localparam logic [7:0]             WIN_N = 8'(WINDOW);
  localparam logic signed [ACC_W:0]  THR_P = (ACC_W+1)'(THRESH);
  localparam logic signed [ACC_W:0]  THR_N = -THR_P;

  state_t                   state, state_nxt;
  logic [7:0]               cnt, cnt_inc;
  logic                     accept, hs, close, partial_nxt, partial_q;
  logic signed [DISP_W-1:0] d;
  logic signed [ACC_W-1:0]  win_sum;
  logic signed [ACC_W:0]    sum_x;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == REPORT);
  assign accept    = in_valid && in_ready;
  assign hs        = out_valid && out_ready;
  assign d         = disp_of(count);

  // Sample count including a sample accepted this very cycle, so a flush in
  // the same cycle as an accept sees that sample.
  assign cnt_inc     = cnt + {7'd0, accept};
  assign close       = in_ready && (cnt_inc != '0) &&
                       ((accept && cnt_inc == WIN_N) || flush);
  assign partial_nxt = (cnt_inc != WIN_N);

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (close)     state_nxt = REPORT;
      REPORT:  if (out_ready) state_nxt = ACCUM;
      default:                state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ACCUM;
      cnt       <= '0;
      partial_q <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs)          cnt <= '0;
      else if (accept) cnt <= cnt_inc;
      if (close)       partial_q <= partial_nxt;
      if (accept && count > 4'd8) err <= 1'b1;
    end
  end

  // Window sum holds naturally in REPORT: nothing is accepted there, and it
  // clears on the report handshake.
  sat_acc #(.ACC_W(ACC_W)) u_win (
    .clk   (clk),
    .reset (reset),
    .clr   (hs),
    .en    (accept),
    .d     (d),
    .acc   (win_sum)
  );

  sat_acc #(.ACC_W(ACC_W)) u_run (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .en    (accept),
    .d     (d),
    .acc   (running_disp)
  );

  // Report fields are driven only while a report is presented.
  assign sum_x         = {win_sum[ACC_W-1], win_sum};
  assign out_sum       = out_valid ? win_sum : '0;
  assign out_imbalance = out_valid && ((sum_x > THR_P) || (sum_x < THR_N));
  assign out_partial   = out_valid && partial_q;

endmodule
